// File: rtl/decode_hz_stage_pkg.sv
// Shared RV32I decode constants and immediate-format selection for the ID stage.
package decode_hz_stage_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BCC   = 7'b1100011;
  localparam logic [6:0] OP_LCC   = 7'b0000011;
  localparam logic [6:0] OP_SCC   = 7'b0100011;
  localparam logic [6:0] OP_MCC   = 7'b0010011;
  localparam logic [6:0] OP_RCC   = 7'b0110011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  function automatic imm_type_e imm_type(input logic [6:0] opc);
    case (opc)
      OP_SCC:          return IMM_S;
      OP_BCC:          return IMM_B;
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:          return IMM_J;
      default:         return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/decode_hz_stage_id_decode_ctl.sv
// Combinational RV32I decode: immediate generation, operand usage, write enable, opcode flags.
module id_decode_ctl
  import decode_hz_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            wen,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            is_sys
);

  logic [6:0]  opc;
  logic [31:0] imm32;

  assign opc = inst[6:0];

  always_comb begin
    imm32 = '0;
    case (imm_type(opc))
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'h000};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = {{20{inst[31]}}, inst[31:20]};
    endcase
  end

  assign imm = XLEN'(signed'(imm32));

  always_comb begin
    uses_rs1  = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    uses_rs2  = (opc == OP_BCC || opc == OP_SCC || opc == OP_RCC);
    wen       = (inst[11:7] != 5'd0) && !(opc == OP_BCC || opc == OP_SCC);
    is_load   = (opc == OP_LCC);
    is_store  = (opc == OP_SCC);
    is_branch = (opc == OP_BCC);
    is_jal    = (opc == OP_JAL);
    is_jalr   = (opc == OP_JALR);
    is_sys    = (opc == OP_SYS);
  end

endmodule

// File: rtl/decode_hz_stage.sv
// RV32I ID stage with operand forwarding, load-use bubble insertion and the ID/EX register.
module decode_hz_stage
  import decode_hz_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RA_W        = 5,
  parameter bit FWD_WB      = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   if_valid,
  input  logic [XLEN-1:0]        if_pc,
  input  logic [31:0]            if_inst,
  output logic                   id_ready,
  output logic [RA_W-1:0]        rf_rs1_addr,
  output logic [RA_W-1:0]        rf_rs2_addr,
  input  logic [XLEN-1:0]        rf_rs1_data,
  input  logic [XLEN-1:0]        rf_rs2_data,
  input  logic [XLEN-1:0]        ex_alu,
  input  logic [RA_W-1:0]        mem_rd,
  input  logic                   mem_wen,
  input  logic                   mem_is_load,
  input  logic [XLEN-1:0]        mem_alu,
  input  logic [XLEN-1:0]        mem_load_data,
  input  logic [RA_W-1:0]        wb_rd,
  input  logic                   wb_wen,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   branch_taken,
  input  logic                   ex_stall,
  output logic                   ex_valid,
  output logic [XLEN-1:0]        ex_pc,
  output logic [31:0]            ex_inst,
  output logic [XLEN-1:0]        ex_rs1_val,
  output logic [XLEN-1:0]        ex_rs2_val,
  output logic [RA_W-1:0]        ex_rd,
  output logic [XLEN-1:0]        ex_imm,
  output logic                   ex_wen,
  output logic                   ex_is_load,
  output logic                   ex_is_store,
  output logic                   ex_is_branch,
  output logic                   ex_is_jal,
  output logic                   ex_is_jalr,
  output logic                   ex_is_sys,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [XLEN-1:0] d_imm;
  logic d_uses_rs1, d_uses_rs2, d_wen;
  logic d_load, d_store, d_branch, d_jal, d_jalr, d_sys;
  logic load_use;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  id_decode_ctl #(.XLEN(XLEN)) u_decode (
    .inst      (if_inst),
    .imm       (d_imm),
    .uses_rs1  (d_uses_rs1),
    .uses_rs2  (d_uses_rs2),
    .wen       (d_wen),
    .is_load   (d_load),
    .is_store  (d_store),
    .is_branch (d_branch),
    .is_jal    (d_jal),
    .is_jalr   (d_jalr),
    .is_sys    (d_sys)
  );

  assign rf_rs1_addr = if_inst[15 +: RA_W];
  assign rf_rs2_addr = if_inst[20 +: RA_W];

  // A load in EX has no data yet; it must drop to MEM before its consumer can capture.
  assign load_use = if_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                    (((ex_rd == rf_rs1_addr) && d_uses_rs1) ||
                     ((ex_rd == rf_rs2_addr) && d_uses_rs2));

  assign id_ready = branch_taken || !(ex_stall || load_use);

  function automatic logic [XLEN-1:0] fwd_sel(input logic [RA_W-1:0] a,
                                              input logic [XLEN-1:0] rf);
    if (a == '0)
      return rf;
    else if (ex_valid && ex_wen && !ex_is_load && ex_rd == a)
      return ex_alu;
    else if (mem_wen && mem_rd == a)
      return mem_is_load ? mem_load_data : mem_alu;
    else if (FWD_WB && wb_wen && wb_rd == a)
      return wb_data;
    else
      return rf;
  endfunction

  always_comb begin
    fwd_rs1 = fwd_sel(rf_rs1_addr, rf_rs1_data);
    fwd_rs2 = fwd_sel(rf_rs2_addr, rf_rs2_data);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_inst      <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_rd        <= '0;
      ex_imm       <= '0;
      ex_wen       <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_is_store  <= 1'b0;
      ex_is_branch <= 1'b0;
      ex_is_jal    <= 1'b0;
      ex_is_jalr   <= 1'b0;
      ex_is_sys    <= 1'b0;
      stall_count  <= '0;
    end else if (branch_taken || (!ex_stall && (load_use || !if_valid))) begin
      // Flush, load-use bubble and idle cycle all leave an inert bubble in ID/EX.
      ex_valid     <= 1'b0;
      ex_inst      <= '0;
      ex_wen       <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_is_store  <= 1'b0;
      ex_is_branch <= 1'b0;
      ex_is_jal    <= 1'b0;
      ex_is_jalr   <= 1'b0;
      ex_is_sys    <= 1'b0;
      if (!branch_taken && load_use && stall_count != '1)
        stall_count <= stall_count + STALL_CNT_W'(1);
    end else if (!ex_stall) begin
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_inst      <= if_inst;
      ex_rs1_val   <= fwd_rs1;
      ex_rs2_val   <= fwd_rs2;
      ex_rd        <= if_inst[7 +: RA_W];
      ex_imm       <= d_imm;
      ex_wen       <= d_wen;
      ex_is_load   <= d_load;
      ex_is_store  <= d_store;
      ex_is_branch <= d_branch;
      ex_is_jal    <= d_jal;
      ex_is_jalr   <= d_jalr;
      ex_is_sys    <= d_sys;
    end
  end

endmodule

// File: tb/tb_decode_hz_stage.sv
// Directed and randomized checks of decode_hz_stage against a behavioural ID/EX model.
module tb_decode_hz_stage;

  logic        CLK = 1'b0;
  logic        RST, if_valid, id_ready;
  logic [31:0] if_pc, if_inst, rf_rs1_data, rf_rs2_data, ex_alu;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, mem_rd, wb_rd, ex_rd;
  logic        mem_wen, mem_is_load, wb_wen, branch_taken, ex_stall;
  logic [31:0] mem_alu, mem_load_data, wb_data;
  logic        ex_valid, ex_wen, ex_is_load, ex_is_store, ex_is_branch;
  logic        ex_is_jal, ex_is_jalr, ex_is_sys;
  logic [31:0] ex_pc, ex_inst, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [15:0] stall_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 CLK = ~CLK;

  decode_hz_stage #(.XLEN(32), .RA_W(5), .FWD_WB(1'b1), .STALL_CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .id_ready(id_ready), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .ex_alu(ex_alu),
    .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_is_load(mem_is_load), .mem_alu(mem_alu),
    .mem_load_data(mem_load_data), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
    .branch_taken(branch_taken), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_inst(ex_inst), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_is_sys(ex_is_sys), .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    bit        valid;
    bit [31:0] pc, inst, rs1v, rs2v, imm;
    bit [4:0]  rd;
    bit        wen;
    bit [5:0]  flags;  // load, store, branch, jal, jalr, sys
  } idex_t;

  idex_t       m;
  int unsigned scnt;

  function automatic bit [31:0] ref_imm(input bit [31:0] i);
    int v;
    case (i[6:0])
      7'h37, 7'h17: v = {i[31:12], 12'h000};
      7'h6f:        v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      7'h63:        v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      7'h23:        v = $signed({i[31:25], i[11:7]});
      default:      v = $signed(i[31:20]);
    endcase
    return v;
  endfunction

  function automatic bit [31:0] ref_operand(input bit [4:0] a, input bit [31:0] rf);
    if (a == 0) return rf;
    if (m.valid && m.wen && !m.flags[5] && m.rd == a) return ex_alu;
    if (mem_wen && mem_rd == a) return mem_is_load ? mem_load_data : mem_alu;
    if (wb_wen && wb_rd == a) return wb_data;
    return rf;
  endfunction

  function automatic idex_t bubble();
    idex_t b = m;
    b.valid = 0; b.inst = 0; b.wen = 0; b.flags = 0;
    return b;
  endfunction

  // One clock: predict from current inputs and model, then compare after the edge.
  task automatic tick();
    bit [6:0] op;
    bit [4:0] a1, a2;
    bit       lu;
    idex_t    nxt;
    int unsigned sn;
    #1;
    op = if_inst[6:0]; a1 = if_inst[19:15]; a2 = if_inst[24:20];
    lu = if_valid && m.valid && m.flags[5] && m.rd != 0 &&
         ((m.rd == a1 && !(op inside {7'h37, 7'h17, 7'h6f})) ||
          (m.rd == a2 && (op inside {7'h63, 7'h23, 7'h33})));
    if (!RST) begin
      check("id_ready", id_ready, branch_taken || !(ex_stall || lu));
      check("rs1_addr", rf_rs1_addr, a1);
      check("rs2_addr", rf_rs2_addr, a2);
    end
    nxt = m; sn = scnt;
    if (RST) begin
      nxt = '0; sn = 0;
    end else if (branch_taken) begin
      nxt = bubble();
    end else if (ex_stall) begin
      nxt = m;
    end else if (lu) begin
      nxt = bubble();
      if (sn != 16'hFFFF) sn++;
    end else if (if_valid) begin
      nxt.valid = 1;
      nxt.pc    = if_pc;
      nxt.inst  = if_inst;
      nxt.rs1v  = ref_operand(a1, rf_rs1_data);
      nxt.rs2v  = ref_operand(a2, rf_rs2_data);
      nxt.imm   = ref_imm(if_inst);
      nxt.rd    = if_inst[11:7];
      nxt.wen   = if_inst[11:7] != 0 && op != 7'h63 && op != 7'h23;
      nxt.flags = {op == 7'h03, op == 7'h23, op == 7'h63, op == 7'h6f, op == 7'h67, op == 7'h73};
    end else begin
      nxt = bubble();
    end
    @(posedge CLK);
    #1;
    m = nxt; scnt = sn;
    check("ex_valid", ex_valid, m.valid);
    check("ex_inst", ex_inst, m.inst);
    check("ex_wen", ex_wen, m.wen);
    check("ex_flags", {ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_is_sys}, m.flags);
    check("stall_count", stall_count, scnt);
    if (m.valid) begin
      check("ex_pc", ex_pc, m.pc);
      check("ex_rs1_val", ex_rs1_val, m.rs1v);
      check("ex_rs2_val", ex_rs2_val, m.rs2v);
      check("ex_rd", ex_rd, m.rd);
      check("ex_imm", ex_imm, m.imm);
    end
    @(negedge CLK);
  endtask

  task automatic quiet_inputs();
    if_valid = 0; if_pc = 0; if_inst = 0; rf_rs1_data = 0; rf_rs2_data = 0; ex_alu = 0;
    mem_rd = 0; mem_wen = 0; mem_is_load = 0; mem_alu = 0; mem_load_data = 0;
    wb_rd = 0; wb_wen = 0; wb_data = 0; branch_taken = 0; ex_stall = 0;
  endtask

  task automatic rand_inputs();
    bit [6:0] ops [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    bit [31:0] i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 9)];
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    if_inst = i;
    if_valid = $urandom_range(0, 9) != 0;
    if_pc = $urandom & 32'hFFFF_FFFC;
    rf_rs1_data = $urandom; rf_rs2_data = $urandom; ex_alu = $urandom;
    mem_rd = 5'($urandom_range(0, 3)); mem_wen = 1'($urandom); mem_is_load = 1'($urandom);
    mem_alu = $urandom; mem_load_data = $urandom;
    wb_rd = 5'($urandom_range(0, 3)); wb_wen = 1'($urandom); wb_data = $urandom;
    branch_taken = $urandom_range(0, 11) == 0;
    ex_stall = $urandom_range(0, 5) == 0;
  endtask

  idex_t snap;

  initial begin
    m = '0; scnt = 0;
    quiet_inputs();
    RST = 1;
    @(negedge CLK);
    tick(); tick();
    RST = 0;
    #1;
    check("t1_ready", id_ready, 1);
    check("t1_valid", ex_valid, 0);
    check("t1_inst", ex_inst, 0);
    check("t1_scnt", stall_count, 0);

    // addi x1,x0,5 ; add x2,x1,x1 with EX result forwarded
    if_valid = 1; if_pc = 32'h100; if_inst = 32'h0050_0093;
    tick();
    if_pc = 32'h104; if_inst = 32'h0010_8133; ex_alu = 5;
    rf_rs1_data = 32'h1111; rf_rs2_data = 32'h2222;
    tick();
    check("t2_rs1", ex_rs1_val, 5);
    check("t2_rs2", ex_rs2_val, 5);

    // lw x3,0(x0) ; add x4,x3,x0 : one bubble, then forward the load data from MEM
    quiet_inputs(); if_valid = 1; if_pc = 32'h200; if_inst = 32'h0000_2183;
    tick();
    if_pc = 32'h204; if_inst = 32'h0001_8233;
    #1 check("t3_ready", id_ready, 0);
    tick();
    check("t3_bubble", ex_valid, 0);
    check("t3_scnt", stall_count, 1);
    mem_rd = 3; mem_wen = 1; mem_is_load = 1; mem_load_data = 32'hDEAD_BEEF; mem_alu = 32'h77;
    tick();
    check("t3_fwd", ex_rs1_val, 32'hDEAD_BEEF);
    check("t3_valid", ex_valid, 1);

    // writes to x0 anywhere downstream must never be forwarded
    quiet_inputs(); if_valid = 1; if_inst = 32'h0550_0013;
    tick();
    if_inst = 32'h0000_02b3; ex_alu = 32'h55;
    mem_rd = 0; mem_wen = 1; mem_alu = 32'h55; mem_load_data = 32'h55;
    wb_rd = 0; wb_wen = 1; wb_data = 32'h55;
    tick();
    check("t4_rs1", ex_rs1_val, 0);
    check("t4_rs2", ex_rs2_val, 0);

    // flush beats stall
    quiet_inputs(); if_valid = 1; if_pc = 32'h300; if_inst = 32'h0010_8133;
    tick();
    branch_taken = 1; ex_stall = 1;
    tick();
    check("t5_valid", ex_valid, 0);
    check("t5_inst", ex_inst, 0);

    // three stall cycles hold the ID/EX contents
    quiet_inputs(); if_valid = 1; if_pc = 32'h400; if_inst = 32'hFFF1_0193;
    tick();
    snap = m;
    for (int k = 0; k < 3; k++) begin
      rand_inputs(); branch_taken = 0; ex_stall = 1;
      #1 check("t6_ready", id_ready, 0);
      tick();
    end
    check("t6_pc", ex_pc, snap.pc);
    check("t6_inst", ex_inst, snap.inst);
    check("t6_imm", ex_imm, snap.imm);
    check("t6_rs1", ex_rs1_val, snap.rs1v);

    for (int k = 0; k < 500; k++) begin
      rand_inputs();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
